// File: rtl/mem_wb_stage_reg.sv
//==============================================================================
// Module   : mem_wb_stage_reg
// Brief    : MEM/WB pipeline register with load formatting, stall-safe
//            capture of synchronous-memory read data and a retire counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_wb_stage_reg #(
    parameter int XLEN    = 32,   // 32 or 64 only
    parameter int RADDR_W = 5,
    parameter int CNT_W   = 32,
    localparam int OFS_W  = $clog2(XLEN / 8)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid,
    input  logic               mem_load,
    input  logic               mem_reg_write,
    input  logic [2:0]         mem_funct3,
    input  logic [OFS_W-1:0]   mem_addr_lo,
    input  logic [XLEN-1:0]    mem_read_data,
    input  logic [XLEN-1:0]    mem_result,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               stall,
    input  logic               flush,
    output logic               wb_valid,
    output logic               wb_reg_write,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    wb_result,
    output logic [CNT_W-1:0]   retire_count
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic               r_valid;
    logic               r_load;
    logic               r_reg_write;
    logic [2:0]         r_funct3;
    logic [OFS_W-1:0]   r_addr_lo;
    logic [RADDR_W-1:0] r_rd;
    logic [XLEN-1:0]    r_result;
    logic               r_hold_vld;
    logic [XLEN-1:0]    r_hold_buf;
    logic [CNT_W-1:0]   r_retire;

    logic [XLEN-1:0]    w_raw;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [XLEN-1:0]    w_word_s;
    logic [XLEN-1:0]    w_word_z;
    logic [XLEN-1:0]    w_fmt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_load      <= 1'b0;
            r_reg_write <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr_lo   <= '0;
            r_rd        <= '0;
            r_result    <= '0;
            r_hold_vld  <= 1'b0;
            r_hold_buf  <= '0;
            r_retire    <= '0;
        end else begin
            // A flushed slot still counts: it is leaving WB either way.
            if (r_valid && (!stall || flush))
                r_retire <= r_retire + c_cnt_one;

            if (flush) begin
                r_valid     <= 1'b0;
                r_load      <= 1'b0;
                r_reg_write <= 1'b0;
            end else if (!stall) begin
                r_valid     <= mem_valid;
                r_load      <= mem_load;
                r_reg_write <= mem_reg_write;
                r_funct3    <= mem_funct3;
                r_addr_lo   <= mem_addr_lo;
                r_rd        <= mem_rd;
                r_result    <= mem_result;
            end

            // Memory output is only valid in the first WB cycle; latch it
            // on the first stalled edge so wb_data stays stable.
            if (flush || !stall) begin
                r_hold_vld <= 1'b0;
            end else if (!r_hold_vld && r_valid) begin
                r_hold_vld <= 1'b1;
                r_hold_buf <= mem_read_data;
            end
        end
    end

    assign w_raw  = r_hold_vld ? r_hold_buf : mem_read_data;
    assign w_byte = w_raw[{r_addr_lo, 3'b000} +: 8];
    assign w_half = w_raw[{r_addr_lo[OFS_W-1:1], 4'b0000} +: 16];

    generate
        if (XLEN == 64) begin : g_word64
            logic [31:0] w_word;
            assign w_word   = r_addr_lo[OFS_W-1] ? w_raw[63:32] : w_raw[31:0];
            assign w_word_s = {{(XLEN-32){w_word[31]}}, w_word};
            assign w_word_z = {{(XLEN-32){1'b0}}, w_word};
        end else begin : g_word32
            // On a 32-bit datapath both word codes return the raw word.
            assign w_word_s = w_raw;
            assign w_word_z = w_raw;
        end
    endgenerate

    always_comb begin
        w_fmt = w_raw;
        case (r_funct3)
            3'b000:  w_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b100:  w_fmt = {{(XLEN-8){1'b0}}, w_byte};
            3'b001:  w_fmt = {{(XLEN-16){w_half[15]}}, w_half};
            3'b101:  w_fmt = {{(XLEN-16){1'b0}}, w_half};
            3'b010:  w_fmt = w_word_s;
            3'b110:  w_fmt = w_word_z;
            default: w_fmt = w_raw;
        endcase
    end

    assign wb_valid     = r_valid;
    assign wb_reg_write = r_valid & r_reg_write & (r_rd != '0);
    assign wb_rd        = r_rd;
    assign wb_data      = r_load ? w_fmt : r_result;
    assign wb_result    = r_result;
    assign retire_count = r_retire;

endmodule

`default_nettype wire

// File: doc/mem_wb_stage_reg.md
MEM_WB_STAGE_REG -- requirements
Module: mem_wb_stage_reg

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; the only legal values SHALL be 32 and 64.
REQ-002 Parameter: RADDR_W, default 5, register-index width.
REQ-003 Parameter: CNT_W, default 32, retire-counter width.
REQ-004 Derived: OFS_W = log2(XLEN/8), the width of the byte offset (2 for XLEN=32, 3 for XLEN=64).
REQ-005 clk  in  1  clock; all state SHALL update on the rising edge only.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 mem_valid  in  1  the MEM-stage slot holds a real instruction.
REQ-008 mem_load  in  1  the instruction is a load.
REQ-009 mem_reg_write  in  1  the instruction writes the register file.
REQ-010 mem_funct3  in  3  load size/sign code.
REQ-011 mem_addr_lo  in  OFS_W  low bits of the load address.
REQ-012 mem_read_data  in  XLEN  synchronous-memory output; valid during the cycle after MEM, i.e. the WB cycle.
REQ-013 mem_result  in  XLEN  ALU/calculated result.
REQ-014 mem_rd  in  RADDR_W  destination register.
REQ-015 stall  in  1  hold the WB contents.
REQ-016 flush  in  1  insert a bubble.
REQ-017 wb_valid  out  1  the WB slot holds a real instruction.
REQ-018 wb_reg_write  out  1  qualified register-file write enable.
REQ-019 wb_rd  out  RADDR_W  destination register.
REQ-020 wb_data  out  XLEN  final write-back value.
REQ-021 wb_result  out  XLEN  registered calculated result, for forwarding.
REQ-022 retire_count  out  CNT_W  count of retired instructions.

Function
REQ-023 Update priority at each clk edge SHALL be: rst > flush > stall > capture.
REQ-024 Capture (no rst, no flush, no stall) SHALL register mem_valid, mem_load, mem_reg_write, mem_funct3, mem_addr_lo, mem_rd and mem_result, with 1-cycle latency.
REQ-025 Flush SHALL set wb_valid, the load flag and the reg_write flag to 0; the data registers SHALL hold their values (don't-care).
REQ-026 Stall SHALL hold every registered field unchanged.
REQ-027 Raw load word SHALL be hold_buf when hold_vld=1, otherwise mem_read_data (combinational).
REQ-028 hold_vld SHALL set to 1, and hold_buf SHALL load mem_read_data, on an edge where stall=1, hold_vld=0, flush=0 and wb_valid=1.
REQ-029 hold_vld SHALL clear on any edge where stall=0, flush=1 or rst=1.
REQ-030 While stalled, the memory output is free to change; wb_data SHALL remain the value from the first WB cycle.
REQ-031 Load formatting SHALL be combinational from the raw load word, the registered funct3 and the registered addr_lo.
REQ-032 Load decoding: 000 LB = byte at offset addr_lo, sign-extended; 100 LBU = the same byte, zero-extended.
REQ-033 Load decoding: 001 LH = halfword at offset addr_lo[OFS_W-1:1]*2, sign-extended; 101 LHU = the same halfword, zero-extended.
REQ-034 Load decoding: 010 LW = word, sign-extended to XLEN; 110 LWU = word, zero-extended (XLEN=64 only; for XLEN=32, 110 SHALL return the raw word).
REQ-035 Load decoding: 011 LD = raw word (XLEN=64); all other codes SHALL return the raw word.
REQ-036 For XLEN=64, word selection SHALL use addr_lo[2].
REQ-037 Misaligned offsets SHALL not be checked; the lane is selected by the offset bits listed above.
REQ-038 wb_data SHALL equal the formatted load word when the load flag = 1, otherwise wb_result.
REQ-039 wb_reg_write SHALL equal wb_valid & reg_write flag & (wb_rd != 0).
REQ-040 retire_count SHALL increment by 1 on every edge where wb_valid=1, stall=0 and rst=0, wrapping to 0 from all-ones.
REQ-041 retire_count increments when flush and wb_valid are both 1, because the slot is leaving WB.
REQ-042 stall and flush in the same cycle: flush SHALL win, and hold_vld SHALL clear.

Reset
REQ-043 Reset values: wb_valid=0, load flag=0, reg_write flag=0, wb_rd=0, wb_result=0, funct3=0, addr_lo=0, hold_vld=0, hold_buf=0, retire_count=0.
REQ-044 Consequently wb_reg_write=0 and wb_data=0 in the cycle after reset.
REQ-045 rst asserted mid-stall SHALL discard the held instruction and clear hold_vld.

Verification
REQ-046 LB: funct3=000, addr_lo=2, mem_read_data=0x12F45678 -> wb_data=0xFFFFFFF4, wb_reg_write=1 (rd=7).
REQ-047 LHU: funct3=101, addr_lo=2, mem_read_data=0x8001ABCD -> wb_data=0x00008001.
REQ-048 Non-load: mem_result=0xDEADBEEF, rd=0, reg_write=1 -> wb_data=0xDEADBEEF, wb_reg_write=0.
REQ-049 Load with read data 0x11111111, stall for 3 cycles while mem_read_data changes to 0x22222222 -> wb_data stays at 0x11111111 throughout, and retire_count increments once, at stall release.
REQ-050 Flush plus stall on a valid slot -> next cycle wb_valid=0, wb_reg_write=0, hold_vld=0, retire_count+1.
REQ-051 With CNT_W=4, retire 16 instructions -> retire_count reads 0; rst mid-stream -> all outputs return to the REQ-043 values on the next edge.
